freq_display: RTL and testbench
===============================

# freq_display

Downstream consumer of the frequency-measurement stage. Takes the 32-bit binary frequency word (Hz) and its enable, converts it to eight packed BCD digits with a sequential double-dabble engine, and drives an 8-digit multiplexed common-anode 7-segment display with leading-zero blanking. It also exports the latched BCD value and an overflow flag for other consumers, such as a UART reporter.

## Interface
- SCAN_DIV, 50_000, aclk cycles per digit slot (1 kHz per digit at 50 MHz); legal range 2..2^20
- BLANK_LZ, 1, 1 = blank leading zeros; digit 0 is never blanked
- aclk  in  1  system clock, 50 MHz
- rstn  in  1  reset: asynchronous, active-low
- freq_en  in  1  freq is valid while high
- freq  in  32  measured frequency, unsigned binary, Hz
- bcd  out  32  last converted value, 8 packed BCD digits; [3:0] is the units digit
- bcd_valid  out  1  one-cycle pulse when bcd is updated
- ovf  out  1  last conversion was > 99_999_999
- seg_n  out  8  active-low segments; [7]=dp, [6:0]=g,f,e,d,c,b,a
- an_n  out  8  active-low one-hot digit select; [0] = units digit

## Operation
- Conversion FSM has three states: IDLE, SHIFT, DONE.
- IDLE: if freq_en=1, load freq into a 32-bit shift register, clear the 40-bit BCD accumulator and the iteration counter, then go to SHIFT. If freq_en=0, stay in IDLE.
- SHIFT, each cycle: for each of the 10 accumulator nibbles, add 3 if the nibble is >= 5. Then shift {acc, bin} left by 1. Increment the counter. After the 32nd shift, go to DONE.
- DONE:
  - If acc[39:32] != 0, set bcd=32'h9999_9999 and ovf=1 (saturate).
  - Otherwise set bcd=acc[31:0] and ovf=0.
  - Pulse bcd_valid and return to IDLE.
- Conversion is continuous: while freq_en stays high, a new conversion starts immediately after DONE.
- freq is sampled only at the IDLE load. Changes to freq during SHIFT are ignored.
- freq_en falling during SHIFT does not abort the conversion.
- bcd and ovf change only in DONE; the display therefore never shows a partial result.
- Scan:
  - A divider counts 0..SCAN_DIV-1.
  - At terminal count, the digit index advances 0→1→…→7→0 (wraps).
- Digit decode, from digit index i and nibble d = bcd[4i+3:4i]:
  - 0..9: standard patterns, e.g. 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - 10..15: cannot occur; decode as FF.
  - dp is always off (seg_n[7]=1).
- Blanking: when BLANK_LZ=1, digit i>0 shows FF if bcd nibbles 7..i are all zero.
- ovf=1: all digits show 9, and the dp on digit 0 lights (seg_n[7]=0 on digit 0 only).
- an_n = ~(1<<i). seg_n and an_n are registered together, so they always change on the same edge.

## Timing
- Reset values:
  - FSM=IDLE, counters=0, digit index=0.
  - bcd=0, bcd_valid=0, ovf=0, seg_n=8'hFF, an_n=8'hFF.
- Display after reset: in the first cycle after rstn deasserts, outputs register an_n=8'hFE and seg_n=8'hC0 (shows "0").
- Conversion latency: freq_en sampled high in IDLE (edge 0) → 32 SHIFT edges → DONE edge. bcd and bcd_valid are visible 34 cycles after the load edge.
- Refresh period with freq_en held high: one bcd_valid every 34 cycles.
- Reset mid-conversion: immediate return to the reset state. Partial results are discarded, and bcd reverts to 0.
- Digit slot: exactly SCAN_DIV cycles. Full frame: 8*SCAN_DIV cycles.
- Display lag: a new bcd reaches seg_n at the next registered update, 1 cycle after bcd_valid, for the currently selected digit.

## Test plan
- Reset: hold rstn=0 with freq_en=1 → bcd=0, bcd_valid=0, seg_n=FF, an_n=FF. One cycle after release → an_n=FE, seg_n=C0.
- freq=12_345, freq_en=1 → bcd_valid pulses 34 cycles after load with bcd=32'h0001_2345, ovf=0. With SCAN_DIV=4, digits 0..4 show 92,99,B0,A4,F9 and digits 5..7 show FF.
- freq=25_000_000 then 0 → bcd=32'h2500_0000 (digit 7=A4, digit 6=92, digits 0..5=C0). Next conversion gives bcd=0, with only digit 0 lit as C0.
- freq=100_000_000 → ovf=1, bcd=32'h9999_9999, all digits show 90, digit 0 shows 10.
- freq changed mid-SHIFT from 7 to 8 → bcd=7 for that conversion and bcd=8 for the next. freq_en=0 → no further bcd_valid, and bcd holds.
- rstn pulsed low 10 cycles into a conversion → bcd=0, no bcd_valid. After release, the next bcd_valid arrives 34 cycles after the new load.

Source files
------------

// File: rtl/freq_display.sv
// Binary-to-BCD frequency display: a sequential double-dabble converter feeding an
// 8-digit multiplexed common-anode 7-segment driver with leading-zero blanking.
module freq_display #(
  parameter int unsigned SCAN_DIV = 50_000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        aclk,
  input  logic        rstn,
  input  logic        freq_en,
  input  logic [31:0] freq,
  output logic [31:0] bcd,
  output logic        bcd_valid,
  output logic        ovf,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n
);

  localparam int unsigned    DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] bin_q, bin_nxt;
  logic [39:0] acc_q, acc_nxt, acc_adj;
  logic [4:0]  cnt_q, cnt_nxt;
  logic [31:0] bcd_nxt;
  logic        ovf_nxt, valid_nxt;

  logic [DIV_W-1:0] div_q;
  logic [2:0]       digit_idx;
  logic [3:0]       digit;
  logic             blank;
  logic [7:0]       seg_nxt, an_nxt;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin_q     <= bin_nxt;
      acc_q     <= acc_nxt;
      cnt_q     <= cnt_nxt;
      bcd       <= bcd_nxt;
      ovf       <= ovf_nxt;
      bcd_valid <= valid_nxt;
    end
  end

  // Add-3 correction on every nibble before each shift of the double-dabble step.
  always_comb begin
    acc_adj = acc_q;
    for (int n = 0; n < 10; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5)
        acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_q;
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    bcd_nxt   = bcd;
    ovf_nxt   = ovf;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (freq_en) begin
          bin_nxt   = freq;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {acc_nxt, bin_nxt} = {acc_adj, bin_q} << 1;
        cnt_nxt = cnt_q + 5'd1;
        if (cnt_q == 5'd31)
          state_nxt = DONE;
      end
      DONE: begin
        if (acc_q[39:32] != 8'd0) begin
          bcd_nxt = 32'h9999_9999;
          ovf_nxt = 1'b1;
        end else begin
          bcd_nxt = acc_q[31:0];
          ovf_nxt = 1'b0;
        end
        valid_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A digit is blank when it and every more significant nibble are zero.
  always_comb begin
    digit   = bcd[{digit_idx, 2'b00} +: 4];
    blank   = (bcd >> {digit_idx, 2'b00}) == 32'd0;
    seg_nxt = seg7(digit);
    if (ovf)
      seg_nxt = (digit_idx == 3'd0) ? 8'h10 : 8'h90;
    else if (BLANK_LZ && digit_idx != 3'd0 && blank)
      seg_nxt = 8'hFF;
    an_nxt = ~(8'd1 << digit_idx);
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      div_q     <= '0;
      digit_idx <= '0;
      seg_n     <= 8'hFF;
      an_n      <= 8'hFF;
    end else begin
      if (div_q == DIV_LAST) begin
        div_q     <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      seg_n <= seg_nxt;
      an_n  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_freq_display.sv
// Self-checking bench for freq_display: a cycle-level behavioural model compared on
// every negedge, plus directed vectors with hand-computed BCD and segment patterns.
module tb_freq_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam bit          BLANK_LZ = 1'b1;

  logic        aclk;
  logic        rstn;
  logic        freq_en;
  logic [31:0] freq;
  logic [31:0] bcd;
  logic        bcd_valid;
  logic        ovf;
  logic [7:0]  seg_n;
  logic [7:0]  an_n;

  int errors = 0;
  int checks = 0;
  bit check_on = 1'b0;

  freq_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(BLANK_LZ)) dut (
    .aclk(aclk), .rstn(rstn), .freq_en(freq_en), .freq(freq),
    .bcd(bcd), .bcd_valid(bcd_valid), .ovf(ovf), .seg_n(seg_n), .an_n(an_n)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    int unsigned q;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    r = '0;
    q = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(q % 10);
      q = q / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_seg(input int idx, input logic [31:0] b, input logic o);
    logic [7:0] pats [10];
    logic [3:0] d;
    pats = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (o) return (idx == 0) ? 8'h10 : 8'h90;
    if (BLANK_LZ && idx > 0 && (b >> (4*idx)) == 32'd0) return 8'hFF;
    d = 4'((b >> (4*idx)) & 32'hF);
    return (d < 4'd10) ? pats[d] : 8'hFF;
  endfunction

  // Model: a conversion is a fixed 34-edge job (load, 32 shifts, done) whose result is
  // plain decimal arithmetic; the display shows slot (edges/SCAN_DIV)%8 one edge late.
  int          m_edges;
  int          m_phase;
  logic [31:0] m_val;
  logic [31:0] m_bcd;
  logic        m_ovf;
  logic        m_valid;
  logic [7:0]  m_seg;
  logic [7:0]  m_an;

  always @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      m_edges <= 0;
      m_phase <= 0;
      m_val   <= '0;
      m_bcd   <= '0;
      m_ovf   <= 1'b0;
      m_valid <= 1'b0;
      m_seg   <= 8'hFF;
      m_an    <= 8'hFF;
    end else begin
      m_seg   <= exp_seg((m_edges / SCAN_DIV) % 8, m_bcd, m_ovf);
      m_an    <= ~(8'd1 << ((m_edges / SCAN_DIV) % 8));
      m_edges <= m_edges + 1;
      m_valid <= 1'b0;
      if (m_phase == 0) begin
        if (freq_en) begin
          m_val   <= freq;
          m_phase <= 1;
        end
      end else if (m_phase < 33) begin
        m_phase <= m_phase + 1;
      end else begin
        m_bcd   <= to_bcd(m_val);
        m_ovf   <= (m_val > 32'd99_999_999);
        m_valid <= 1'b1;
        m_phase <= 0;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge aclk) begin
    if (check_on) begin
      check_output("model_bcd", bcd, m_bcd);
      check_output("model_bcd_valid", 32'(bcd_valid), 32'(m_valid));
      check_output("model_ovf", 32'(ovf), 32'(m_ovf));
      check_output("model_seg_n", 32'(seg_n), 32'(m_seg));
      check_output("model_an_n", 32'(an_n), 32'(m_an));
    end
  end

  // Caller guarantees the next posedge is a load edge; start counts edges already seen.
  task automatic wait_valid(input int start, output int n);
    bit got;
    got = 1'b0;
    n = start;
    while (!got && n < 100) begin
      @(posedge aclk);
      n++;
      @(negedge aclk);
      if (bcd_valid) got = 1'b1;
    end
    if (!got) check_output("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture_frame(input string name, input logic [63:0] expected);
    logic [7:0] cap [8];
    for (int k = 0; k < 8; k++) cap[k] = 8'h00;
    repeat (2) @(negedge aclk);
    for (int c = 0; c < 8 * SCAN_DIV; c++) begin
      for (int k = 0; k < 8; k++)
        if (an_n == ~(8'd1 << k)) cap[k] = seg_n;
      @(negedge aclk);
    end
    for (int k = 0; k < 8; k++)
      check_output($sformatf("%s_digit%0d", name, k), 32'(cap[k]), 32'(expected[8*k +: 8]));
  endtask

  task automatic apply_stimulus(input logic en, input logic [31:0] f);
    freq_en = en;
    freq    = f;
  endtask

  initial begin
    int n;
    int seen;
    rstn = 1'b0;
    apply_stimulus(1'b1, 32'd12_345);
    repeat (3) @(negedge aclk);
    check_on = 1'b1;
    check_output("reset_bcd", bcd, 32'd0);
    check_output("reset_valid", 32'(bcd_valid), 32'd0);
    check_output("reset_seg_n", 32'(seg_n), 32'hFF);
    check_output("reset_an_n", 32'(an_n), 32'hFF);

    rstn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check_output("release_an_n", 32'(an_n), 32'hFE);
    check_output("release_seg_n", 32'(seg_n), 32'hC0);
    wait_valid(1, n);
    check_output("latency_12345", 32'(n), 32'd34);
    check_output("bcd_12345", bcd, 32'h0001_2345);
    check_output("ovf_12345", 32'(ovf), 32'd0);
    capture_frame("frame_12345", 64'hFFFF_FFF9_A4B0_9992);

    wait_valid(0, n);
    apply_stimulus(1'b1, 32'd25_000_000);
    wait_valid(0, n);
    check_output("period_25m", 32'(n), 32'd34);
    check_output("bcd_25m", bcd, 32'h2500_0000);
    capture_frame("frame_25m", 64'hA492_C0C0_C0C0_C0C0);

    wait_valid(0, n);
    apply_stimulus(1'b1, 32'd0);
    wait_valid(0, n);
    check_output("bcd_zero", bcd, 32'h0000_0000);
    capture_frame("frame_zero", 64'hFFFF_FFFF_FFFF_FFC0);

    wait_valid(0, n);
    apply_stimulus(1'b1, 32'd100_000_000);
    wait_valid(0, n);
    check_output("bcd_ovf", bcd, 32'h9999_9999);
    check_output("ovf_flag", 32'(ovf), 32'd1);
    capture_frame("frame_ovf", 64'h9090_9090_9090_9010);

    wait_valid(0, n);
    apply_stimulus(1'b1, 32'd7);
    repeat (5) @(negedge aclk);
    apply_stimulus(1'b1, 32'd8);
    wait_valid(5, n);
    check_output("latency_7", 32'(n), 32'd34);
    check_output("bcd_7_ignores_change", bcd, 32'h0000_0007);
    check_output("ovf_cleared", 32'(ovf), 32'd0);
    wait_valid(0, n);
    check_output("bcd_8", bcd, 32'h0000_0008);
    apply_stimulus(1'b0, 32'd8);
    seen = 0;
    repeat (100) begin
      @(negedge aclk);
      if (bcd_valid) seen++;
    end
    check_output("no_valid_when_disabled", 32'(seen), 32'd0);
    check_output("bcd_holds", bcd, 32'h0000_0008);

    apply_stimulus(1'b1, 32'd99);
    repeat (3) @(negedge aclk);
    apply_stimulus(1'b0, 32'd99);
    wait_valid(3, n);
    check_output("latency_en_drop", 32'(n), 32'd34);
    check_output("bcd_en_drop", bcd, 32'h0000_0099);

    apply_stimulus(1'b1, 32'd4_321);
    repeat (10) @(negedge aclk);
    rstn = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge aclk);
      if (bcd_valid) seen++;
    end
    check_output("midreset_bcd", bcd, 32'd0);
    check_output("midreset_no_valid", 32'(seen), 32'd0);
    rstn = 1'b1;
    wait_valid(0, n);
    check_output("latency_after_reset", 32'(n), 32'd34);
    check_output("bcd_after_reset", bcd, 32'h0000_4321);
    apply_stimulus(1'b0, 32'd0);
    repeat (4) @(negedge aclk);

    check_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
